// File: rtl/nodf_module_if.sv
// -----------------------------------------------------------------------------
// nodf_module_if
//
// Passive monitor for the ap_start/ap_ready/ap_done/ap_continue handshake of
// one HLS non-dataflow block. It counts transactions and measures completion
// latency and start interval. It flags protocol misuse. Once the finish
// request has been seen, every statistic is frozen.
//
// Ports
//   clock          rising-edge sampling clock
//   reset          asynchronous, active-low reset
//   ap_start       observed start request
//   ap_ready       observed ready (start accepted on ap_start & ap_ready)
//   ap_done        observed done
//   ap_continue    observed continue (tie high when the block has none)
//   finish         end-of-simulation request
//   state          0=IDLE 1=BUSY 2=STALL 3=FINISHED
//   start_cnt      accepted starts
//   done_cnt       completed transactions
//   outstanding    started but not yet completed (saturates at DEPTH)
//   cycle_cnt      free-running cycle counter
//   busy_cycles    cycles that began with work outstanding
//   stall_cycles   cycles with ap_done held off by ap_continue
//   last_latency   latency of the most recent completion
//   min_latency    smallest completion latency (all ones until the first)
//   max_latency    largest completion latency
//   last_interval  cycles between the two most recent accepted starts
//   lat_valid      one-cycle pulse when last_latency updates
//   finished       sticky, set when finish is sampled high
//   err_underflow  done seen with nothing outstanding
//   err_overflow   start accepted while the timestamp FIFO was full
//   err_start_drop start request withdrawn before it was accepted
// -----------------------------------------------------------------------------
module nodf_module_if #(
   parameter int CNT_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ap_start,
   input  logic                    ap_ready,
   input  logic                    ap_done,
   input  logic                    ap_continue,
   input  logic                    finish,
   output logic [1:0]              state,
   output logic [CNT_W-1:0]        start_cnt,
   output logic [CNT_W-1:0]        done_cnt,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [CNT_W-1:0]        busy_cycles,
   output logic [CNT_W-1:0]        stall_cycles,
   output logic [CNT_W-1:0]        last_latency,
   output logic [CNT_W-1:0]        min_latency,
   output logic [CNT_W-1:0]        max_latency,
   output logic [CNT_W-1:0]        last_interval,
   output logic                    lat_valid,
   output logic                    finished,
   output logic                    err_underflow,
   output logic                    err_overflow,
   output logic                    err_start_drop
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OUT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY     = 2'd1,
      ST_STALL    = 2'd2,
      ST_FINISHED = 2'd3
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  ts_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  prev_ts;
   logic              have_prev;
   logic              req_pend;

   logic              ev_start;
   logic              ev_done;
   logic              ev_stall;
   logic              fifo_empty;
   logic              fifo_full;
   logic              bypass;
   logic              pop;
   logic              push;
   logic              lat_upd;
   logic [CNT_W-1:0]  lat_new;
   logic [OUT_W-1:0]  out_nxt;

   // Pointer advance that also works when DEPTH is not a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign state = state_q;

   always_comb begin
      ev_start   = ap_start & ap_ready;
      ev_done    = ap_done & ap_continue;
      ev_stall   = ap_done & ~ap_continue;
      fifo_empty = (outstanding == '0);
      fifo_full  = (outstanding == OUT_W'(DEPTH));
      // A start and a done in the same cycle on an empty FIFO pair with each
      // other directly: zero latency, nothing stored.
      bypass     = ev_start & ev_done & fifo_empty;
      pop        = ev_done & ~fifo_empty;
      // When full, a start can only be stored if a done frees a slot now.
      push       = ev_start & ~bypass & (~fifo_full | pop);
      lat_upd    = pop | bypass;
      lat_new    = bypass ? '0 : cycle_cnt - ts_mem[rd_ptr];
      out_nxt    = outstanding + OUT_W'(push) - OUT_W'(pop);
   end

   // Timestamp storage and the last start time are data only; no reset.
   always_ff @(posedge clock) begin
      if (!finished) begin
         if (push)
            ts_mem[wr_ptr] <= cycle_cnt;
         if (ev_start)
            prev_ts <= cycle_cnt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         have_prev      <= 1'b0;
         req_pend       <= 1'b0;
         start_cnt      <= '0;
         done_cnt       <= '0;
         outstanding    <= '0;
         cycle_cnt      <= '0;
         busy_cycles    <= '0;
         stall_cycles   <= '0;
         last_latency   <= '0;
         min_latency    <= '1;
         max_latency    <= '0;
         last_interval  <= '0;
         lat_valid      <= 1'b0;
         finished       <= 1'b0;
         err_underflow  <= 1'b0;
         err_overflow   <= 1'b0;
         err_start_drop <= 1'b0;
      end else begin
         req_pend  <= ap_start & ~ap_ready;
         lat_valid <= 1'b0;
         // The edge that samples finish still updates; afterwards all holds.
         if (!finished) begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            outstanding <= out_nxt;
            if (outstanding != '0)
               busy_cycles <= busy_cycles + 1'b1;
            if (ev_stall)
               stall_cycles <= stall_cycles + 1'b1;
            if (req_pend && !ap_start)
               err_start_drop <= 1'b1;

            if (ev_start) begin
               start_cnt <= start_cnt + 1'b1;
               have_prev <= 1'b1;
               if (have_prev)
                  last_interval <= cycle_cnt - prev_ts;
               if (!push && !bypass)
                  err_overflow <= 1'b1;
            end
            if (push)
               wr_ptr <= next_ptr(wr_ptr);

            if (ev_done) begin
               done_cnt <= done_cnt + 1'b1;
               if (!lat_upd)
                  err_underflow <= 1'b1;
            end
            if (pop)
               rd_ptr <= next_ptr(rd_ptr);
            if (lat_upd) begin
               last_latency <= lat_new;
               lat_valid    <= 1'b1;
               if (lat_new < min_latency)
                  min_latency <= lat_new;
               if (lat_new > max_latency)
                  max_latency <= lat_new;
            end

            if (finish)
               finished <= 1'b1;

            if (finish)
               state_q <= ST_FINISHED;
            else if (ev_stall)
               state_q <= ST_STALL;
            else if (out_nxt != '0 || ap_start)
               state_q <= ST_BUSY;
            else
               state_q <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_nodf_module_if.sv
module tb_nodf_module_if;

   localparam int CNT_W = 32;
   localparam int DEPTH = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              ap_start = 1'b0;
   logic              ap_ready = 1'b0;
   logic              ap_done = 1'b0;
   logic              ap_continue = 1'b0;
   logic              finish = 1'b0;
   logic [1:0]        state;
   logic [CNT_W-1:0]  start_cnt, done_cnt, cycle_cnt, busy_cycles, stall_cycles;
   logic [CNT_W-1:0]  last_latency, min_latency, max_latency, last_interval;
   logic [$clog2(DEPTH):0] outstanding;
   logic              lat_valid, finished, err_underflow, err_overflow, err_start_drop;

   nodf_module_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .ap_start       (ap_start),
      .ap_ready       (ap_ready),
      .ap_done        (ap_done),
      .ap_continue    (ap_continue),
      .finish         (finish),
      .state          (state),
      .start_cnt      (start_cnt),
      .done_cnt       (done_cnt),
      .outstanding    (outstanding),
      .cycle_cnt      (cycle_cnt),
      .busy_cycles    (busy_cycles),
      .stall_cycles   (stall_cycles),
      .last_latency   (last_latency),
      .min_latency    (min_latency),
      .max_latency    (max_latency),
      .last_interval  (last_interval),
      .lat_valid      (lat_valid),
      .finished       (finished),
      .err_underflow  (err_underflow),
      .err_overflow   (err_overflow),
      .err_start_drop (err_start_drop)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   string cur_tag = "init";

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
      end
   endfunction

   // Reference model: a queue of start times plus plain counters.
   int unsigned m_q[$];
   int unsigned m_cyc, m_start, m_done, m_busy, m_stall;
   int unsigned m_last_lat, m_min, m_max, m_int, m_prev, m_state;
   bit          m_have_prev, m_lv, m_fin, m_eu, m_eo, m_ed, m_req;

   function automatic void model_reset();
      m_q.delete();
      m_cyc = 0; m_start = 0; m_done = 0; m_busy = 0; m_stall = 0;
      m_last_lat = 0; m_min = 32'hFFFF_FFFF; m_max = 0; m_int = 0; m_prev = 0;
      m_state = 0; m_have_prev = 0; m_lv = 0; m_fin = 0;
      m_eu = 0; m_eo = 0; m_ed = 0; m_req = 0;
   endfunction

   function automatic void model_step(bit st, bit rd, bit dn, bit ct, bit fin);
      bit s, d, k, was_empty;
      int unsigned lat;
      s = st & rd;
      d = dn & ct;
      k = dn & ~ct;
      m_lv = 0;
      if (!m_fin) begin
         was_empty = (m_q.size() == 0);
         if (!was_empty) m_busy++;
         if (k) m_stall++;
         if (m_req && !st) m_ed = 1;
         if (s) begin
            m_start++;
            if (m_have_prev) m_int = m_cyc - m_prev;
            m_prev = m_cyc;
            m_have_prev = 1;
         end
         if (d) begin
            m_done++;
            if (!was_empty || s) begin
               lat = was_empty ? 0 : m_cyc - m_q.pop_front();
               m_last_lat = lat;
               if (lat < m_min) m_min = lat;
               if (lat > m_max) m_max = lat;
               m_lv = 1;
            end else
               m_eu = 1;
         end
         if (s && !(d && was_empty)) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_cyc);
            else m_eo = 1;
         end
         if (fin) m_fin = 1;
         m_cyc++;
         m_state = m_fin ? 3 : k ? 2 : (m_q.size() != 0 || st) ? 1 : 0;
      end
      m_req = st & ~rd;
   endfunction

   function automatic void model_check();
      chk("state", state, m_state);
      chk("start_cnt", start_cnt, m_start);
      chk("done_cnt", done_cnt, m_done);
      chk("outstanding", outstanding, m_q.size());
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("busy_cycles", busy_cycles, m_busy);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("last_latency", last_latency, m_last_lat);
      chk("min_latency", min_latency, m_min);
      chk("max_latency", max_latency, m_max);
      chk("last_interval", last_interval, m_int);
      chk("lat_valid", lat_valid, m_lv);
      chk("finished", finished, m_fin);
      chk("err_underflow", err_underflow, m_eu);
      chk("err_overflow", err_overflow, m_eo);
      chk("err_start_drop", err_start_drop, m_ed);
   endfunction

   task automatic step(input bit st, input bit rd, input bit dn, input bit ct, input bit fin);
      ap_start = st; ap_ready = rd; ap_done = dn; ap_continue = ct; finish = fin;
      @(posedge clock);
      model_step(st, rd, dn, ct, fin);
      #1;
      model_check();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
      #1;
      model_reset();
      @(posedge clock);
      #1;
      model_check();
      chk("rst_min_all_ones", min_latency, 64'hFFFF_FFFF);
      reset = 1'b1;
   endtask

   typedef struct {
      bit          st, rd, dn;
      logic [1:0]  exp_state;
      int          exp_out;
      bit          exp_lv;
      int unsigned exp_lat;
   } vec_t;

   vec_t tbl[16];
   int   pulses;
   logic [CNT_W-1:0] frozen_cyc;

   initial begin
      // Pipelined starts at cycles 2, 4, 6; dones at 10, 11, 15.
      tbl[0]  = '{0, 0, 0, 2'd0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 2'd0, 0, 0, 0};
      tbl[2]  = '{1, 1, 0, 2'd1, 1, 0, 0};
      tbl[3]  = '{0, 0, 0, 2'd1, 1, 0, 0};
      tbl[4]  = '{1, 1, 0, 2'd1, 2, 0, 0};
      tbl[5]  = '{0, 0, 0, 2'd1, 2, 0, 0};
      tbl[6]  = '{1, 1, 0, 2'd1, 3, 0, 0};
      tbl[7]  = '{0, 0, 0, 2'd1, 3, 0, 0};
      tbl[8]  = '{0, 0, 0, 2'd1, 3, 0, 0};
      tbl[9]  = '{0, 0, 0, 2'd1, 3, 0, 0};
      tbl[10] = '{0, 0, 1, 2'd1, 2, 1, 8};
      tbl[11] = '{0, 0, 1, 2'd1, 1, 1, 7};
      tbl[12] = '{0, 0, 0, 2'd1, 1, 0, 7};
      tbl[13] = '{0, 0, 0, 2'd1, 1, 0, 7};
      tbl[14] = '{0, 0, 0, 2'd1, 1, 0, 7};
      tbl[15] = '{0, 0, 1, 2'd0, 0, 1, 9};

      // Idle after reset
      cur_tag = "idle";
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
      chk("cycle_cnt10", cycle_cnt, 10);
      chk("state_idle", state, 0);
      chk("start_cnt0", start_cnt, 0);
      chk("min_init", min_latency, 64'hFFFF_FFFF);

      // Single transaction: start at 5, done at 12
      cur_tag = "single";
      do_reset();
      pulses = 0;
      for (int c = 0; c <= 12; c++) begin
         step(c == 5, c == 5, c == 12, 1, 0);
         if (lat_valid) pulses++;
      end
      chk("lat_pulses", pulses, 1);
      chk("last_latency7", last_latency, 7);
      chk("min7", min_latency, 7);
      chk("max7", max_latency, 7);
      chk("done1", done_cnt, 1);
      chk("busy7", busy_cycles, 7);

      // Table-driven pipelined sequence
      cur_tag = "table";
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].st, tbl[i].rd, tbl[i].dn, 1, 0);
         chk("tbl_state", state, tbl[i].exp_state);
         chk("tbl_outstanding", outstanding, tbl[i].exp_out);
         chk("tbl_lat_valid", lat_valid, tbl[i].exp_lv);
         chk("tbl_last_latency", last_latency, tbl[i].exp_lat);
      end
      chk("tbl_min", min_latency, 7);
      chk("tbl_max", max_latency, 9);
      chk("tbl_interval", last_interval, 2);
      chk("tbl_done", done_cnt, 3);

      // Stall: done held off for 3 cycles
      cur_tag = "stall";
      do_reset();
      step(1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 0);
         chk("stall_state", state, 2);
      end
      step(0, 0, 1, 1, 0);
      chk("stall_cycles3", stall_cycles, 3);
      chk("stall_done1", done_cnt, 1);
      chk("stall_latency4", last_latency, 4);
      step(0, 0, 0, 1, 0);
      chk("stall_after_idle", state, 0);

      // Overflow then underflow
      cur_tag = "ovf";
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0);
      chk("err_overflow", err_overflow, 1);
      chk("outstanding_sat", outstanding, 4);
      chk("start_cnt5", start_cnt, 5);
      step(0, 0, 1, 1, 0);
      chk("ovf_oldest_latency", last_latency, 5);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
      chk("ovf_drained", outstanding, 0);
      chk("no_underflow_yet", err_underflow, 0);
      step(0, 0, 1, 1, 0);
      chk("err_underflow", err_underflow, 1);
      chk("udf_done5", done_cnt, 5);

      // Start withdrawn, then finish and freeze
      cur_tag = "finish";
      do_reset();
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("drop_not_yet", err_start_drop, 0);
      step(0, 0, 0, 1, 0);
      chk("err_start_drop", err_start_drop, 1);
      step(0, 0, 0, 1, 1);
      chk("finished", finished, 1);
      chk("state_finished", state, 3);
      chk("finish_edge_cycle", cycle_cnt, 4);
      frozen_cyc = cycle_cnt;
      for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
      chk("frozen_cycle", cycle_cnt, frozen_cyc);
      chk("frozen_start", start_cnt, 0);
      chk("frozen_done", done_cnt, 0);
      chk("frozen_state", state, 3);

      // Randomized run against the model, with occasional mid-run resets
      cur_tag = "random";
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset();
         step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
              i == 2990);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/nodf_module_if.md
Name: nodf_module_if

Overview:
- Cycle-accurate monitor for one HLS non-dataflow top-level block handshake (ap_start/ap_ready/ap_done/ap_continue).
- Counts transactions and measures per-transaction latency and start interval.
- Flags handshake protocol violations and freezes all statistics when the simulation finish signal asserts.
- Sits beside the DUT in the simulation harness; feeds the status/CSV dump layer and is purely observational.

Parameters:
- CNT_W, 32, width of all counters and latency/interval values.
- DEPTH, 4, start-timestamp FIFO depth (maximum outstanding transactions tracked; power of 2).

Ports:
- clock  in  1  single clock; all sampling on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  observed block start request.
- ap_ready  in  1  observed block ready; a start is accepted when ap_start & ap_ready.
- ap_done  in  1  observed block done.
- ap_continue  in  1  observed continue; tie to 1 when the block has none.
- finish  in  1  end-of-simulation request.
- state  out  2  0=IDLE, 1=BUSY, 2=STALL, 3=FINISHED.
- start_cnt  out  CNT_W  accepted starts.
- done_cnt  out  CNT_W  completed transactions.
- outstanding  out  $clog2(DEPTH)+1  started but not yet completed.
- cycle_cnt  out  CNT_W  free-running cycles since reset.
- busy_cycles  out  CNT_W  cycles with outstanding>0.
- stall_cycles  out  CNT_W  cycles with ap_done & ~ap_continue.
- last_latency, min_latency, max_latency  out  CNT_W  completion latency statistics.
- last_interval  out  CNT_W  cycles between the two most recent accepted starts.
- lat_valid  out  1  one-cycle pulse when last_latency updates.
- finished  out  1  sticky; set when finish is sampled high.
- err_underflow, err_overflow, err_start_drop  out  1  sticky protocol error flags.

Behaviour:
- Reset (asynchronous, reset=0):
  - All counters, outstanding, last_*, max_latency, lat_valid, finished and err_* are 0.
  - min_latency is all ones.
  - state is IDLE.
  - FIFO is emptied.
- Events sampled each rising edge:
  - S (start) = ap_start & ap_ready.
  - D (done) = ap_done & ap_continue.
  - K (stall) = ap_done & ~ap_continue.
- Outputs are registered and reflect events sampled at edge N after edge N; latency is one clock.
- cycle_cnt increments every cycle and wraps modulo 2^CNT_W. Latency and interval are computed as modular differences, so wrap is transparent.
- On S: push cycle_cnt into the FIFO and increment start_cnt.
  - If a previous start exists, last_interval = cycle_cnt − previous start timestamp.
  - The first start leaves last_interval at 0.
- On D: pop the oldest timestamp T and set last_latency = cycle_cnt − T.
  - Update min_latency and max_latency; pulse lat_valid; increment done_cnt.
- Simultaneous S and D:
  - With the FIFO empty: bypass; latency = 0 and outstanding is unchanged.
  - With the FIFO non-empty: pop the oldest entry and push the new one; outstanding is unchanged.
- D with the FIFO empty and no simultaneous S: set err_underflow; counters are unchanged except done_cnt still increments.
- S with the FIFO full and no simultaneous D:
  - Set err_overflow; the timestamp is dropped and start_cnt still increments.
  - outstanding saturates at DEPTH.
  - The next D pairs with the oldest stored timestamp.
- err_start_drop: set when ap_start was 1 and ap_ready was 0 at edge N−1, and ap_start is 0 at edge N (request withdrawn before acceptance).
- busy_cycles increments when outstanding>0 (pre-update value). stall_cycles increments on K.
- State, evaluated on post-update values, in priority order:
  - FINISHED if finished.
  - STALL if K.
  - BUSY if outstanding>0 or ap_start.
  - else IDLE.
- Finish:
  - finished is set at the edge where finish=1.
  - From the following edge, all counters, statistics and error flags hold their values; cycle_cnt also freezes.
  - finished clears only on reset.
- Reset mid-operation discards in-flight timestamps; no error is flagged.

Test Plan:
- Reset, then idle for 10 cycles -> state=IDLE, cycle_cnt=10, start_cnt=0, min_latency=0xFFFFFFFF.
- ap_start/ap_ready high 1 cycle at cycle 5, ap_done high 1 cycle at cycle 12 (ap_continue=1) -> last_latency=7, min_latency=max_latency=7, done_cnt=1, lat_valid a single pulse, busy_cycles=7.
- Pipelined starts at cycles 2, 4, 6 with dones at 10, 11, 15 -> latencies 8, 7, 9; min=7, max=9; last_interval=2; outstanding peaks at 3.
- ap_done high with ap_continue=0 for 3 cycles, then ap_continue=1 -> stall_cycles=3, state=STALL during the stall, then a single done counted.
- Five starts without done (DEPTH=4) -> err_overflow=1, outstanding=4. A done with nothing outstanding -> err_underflow=1.
- ap_start high with ap_ready=0, then dropped -> err_start_drop=1. Assert finish -> finished=1, state=FINISHED, counters frozen on subsequent edges.
